// File: rtl/lc3b_type.sv
// ============================================================================
//  Module      : lc3b_type (package)
//  Description : Shared LC-3b types. Carries the branch target buffer field
//                types, the update-request record buffered by btb_update and
//                the two-bit saturating predictor step function.
//  Revision    : 1.0  initial BTB update slice
// ============================================================================
`default_nettype none

package lc3b_type;

    typedef logic [15:0] lc3b_word;

    typedef logic [2:0]  lc3b_btb_index;
    typedef logic [11:0] lc3b_btb_tag;
    typedef logic [1:0]  lc3b_btb_pred;
    typedef logic [2:0]  lc3b_btb_lru;

    // Weakly-taken: a freshly allocated entry predicts taken but flips
    // after a single not-taken outcome.
    localparam lc3b_btb_pred BTB_PRED_INIT = 2'b10;

    // One resolved-branch update, already split into set index and tag.
    typedef struct packed {
        lc3b_btb_tag   tag;
        lc3b_btb_index index;
        lc3b_word      target;
        logic          taken;
    } btb_upd_entry_t;

    // Two-bit saturating counter step.
    function automatic lc3b_btb_pred btb_pred_next(input lc3b_btb_pred p,
                                                   input logic         taken);
        if (taken) begin
            return (p == 2'b11) ? p : p + 2'd1;
        end
        return (p == 2'b00) ? p : p - 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btb_update_if.sv
// ============================================================================
//  Module      : btb_update_if
//  Description : Resolved-branch update handshake from execute to the BTB
//                update engine. A request transfers when upd_valid and
//                upd_ready are both high on a rising clock edge.
//  Ports       : upd_valid, upd_pc, upd_target, upd_taken (master -> slave)
//                upd_ready (slave -> master)
//  Revision    : 1.0  initial BTB update slice
// ============================================================================
`default_nettype none

interface btb_update_if;
    import lc3b_type::*;

    logic     upd_valid;
    lc3b_word upd_pc;
    lc3b_word upd_target;
    logic     upd_taken;
    logic     upd_ready;

    modport master (
        output upd_valid,
        output upd_pc,
        output upd_target,
        output upd_taken,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_pc,
        input  upd_target,
        input  upd_taken,
        output upd_ready
    );

endinterface

`default_nettype wire

// File: rtl/btb_plru.sv
// ============================================================================
//  Module      : btb_plru
//  Description : Combinational tree pseudo-LRU for a 4-way set. Produces the
//                replacement victim for the current state and the state after
//                touching a given way. Used by both lookup and update paths.
//                Bit map: lru[0]=b0 (root), lru[1]=b1 (ways 0/1),
//                lru[2]=b2 (ways 2/3).
//  Ports       : lru      in  current PLRU bits of the set
//                way      in  way being touched
//                victim   out way to replace next
//                next_lru out PLRU bits after touching 'way'
//  Revision    : 1.0  initial BTB update slice
// ============================================================================
`default_nettype none

module btb_plru
    import lc3b_type::*;
(
    input  lc3b_btb_lru lru,
    input  logic [1:0]  way,
    output logic [1:0]  victim,
    output lc3b_btb_lru next_lru
);

    always_comb begin
        if (lru[0]) begin
            victim = lru[2] ? 2'd3 : 2'd2;
        end else begin
            victim = lru[1] ? 2'd1 : 2'd0;
        end
    end

    // Touching a way points the root at the opposite half and the leaf bit
    // at the sibling; the other half's leaf bit is left alone.
    always_comb begin
        next_lru = lru;
        if (!way[1]) begin
            next_lru[0] = 1'b1;
            next_lru[1] = (way == 2'd0);
        end else begin
            next_lru[0] = 1'b0;
            next_lru[2] = (way == 2'd2);
        end
    end

endmodule

`default_nettype wire

// File: rtl/btb_update.sv
// ============================================================================
//  Module      : btb_update
//  Description : BTB update engine. Buffers resolved-branch updates in a
//                2-entry FIFO and retires each with a READ (fetch set state)
//                followed by a WRITE (single-entry write + PLRU update).
//  Ports       : clk, rst           clock, asynchronous active-high reset
//                upd (slave)        update request handshake
//                rd_index           set index to storage read port
//                rd_tag/valid/pred/lru  set contents for rd_index
//                wr_en, wr_index, wr_way, wr_tag, wr_target, wr_pred
//                                   single-entry storage write
//                wr_lru_en, wr_lru  PLRU write for wr_index
//                busy               work pending or in progress
//  Revision    : 1.0  initial BTB update slice
// ============================================================================
`default_nettype none

module btb_update
    import lc3b_type::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 8
)(
    input  logic                      clk,
    input  logic                      rst,

    btb_update_if.slave               upd,

    output logic [$clog2(SETS)-1:0]   rd_index,
    input  lc3b_btb_tag [WAYS-1:0]    rd_tag,
    input  logic        [WAYS-1:0]    rd_valid,
    input  lc3b_btb_pred [WAYS-1:0]   rd_pred,
    input  lc3b_btb_lru               rd_lru,

    output logic                      wr_en,
    output logic [$clog2(SETS)-1:0]   wr_index,
    output logic [1:0]                wr_way,
    output lc3b_btb_tag               wr_tag,
    output lc3b_word                  wr_target,
    output lc3b_btb_pred              wr_pred,

    output logic                      wr_lru_en,
    output lc3b_btb_lru               wr_lru,

    output logic                      busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    btb_upd_entry_t r_fifo [2];
    logic           r_rd_ptr;
    logic           r_wr_ptr;
    logic [1:0]     r_count;
    logic [1:0]     r_state;

    logic           w_full;
    logic           w_push;
    logic           w_pop;
    logic [1:0]     w_count_nxt;
    btb_upd_entry_t w_new;
    btb_upd_entry_t w_head;
    logic           w_unused_pc0;

    // pc[0] is always zero for LC-3b instruction addresses.
    assign w_unused_pc0 = upd.upd_pc[0];

    assign w_full        = (r_count == 2'd2);
    // Readiness depends only on current occupancy, so a pop in the same
    // cycle never lets a third request in.
    assign upd.upd_ready = ~rst & ~w_full;
    assign w_push        = upd.upd_valid & upd.upd_ready;
    assign w_pop         = (r_state == ST_WRITE);
    assign w_count_nxt   = r_count + {1'b0, w_push} - {1'b0, w_pop};

    assign w_new.tag    = upd.upd_pc[15:4];
    assign w_new.index  = upd.upd_pc[3:1];
    assign w_new.target = upd.upd_target;
    assign w_new.taken  = upd.upd_taken;

    assign w_head = r_fifo[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_rd_ptr  <= 1'b0;
            r_wr_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_new;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    logic [1:0] w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (r_count != 2'd0) w_state_nxt = ST_READ;
            ST_READ:  w_state_nxt = ST_WRITE;
            ST_WRITE: w_state_nxt = (w_count_nxt != 2'd0) ? ST_READ : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign busy = (r_count != 2'd0) || (r_state != ST_IDLE);

    // ------------------------------------------------------------------
    // READ: look up the head's set and capture everything WRITE needs
    // ------------------------------------------------------------------
    logic        w_hit;
    logic [1:0]  w_hit_way;

    assign rd_index = (r_state == ST_READ) ? w_head.index : '0;

    // Scan from the top so the lowest matching way wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = 2'd0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (rd_valid[w] && (rd_tag[w] == w_head.tag)) begin
                w_hit     = 1'b1;
                w_hit_way = 2'(w);
            end
        end
    end

    logic              r_hit;
    logic [1:0]        r_hit_way;
    lc3b_btb_pred      r_hit_pred;
    logic [WAYS-1:0]   r_valid;
    lc3b_btb_lru       r_lru;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit      <= 1'b0;
            r_hit_way  <= 2'd0;
            r_hit_pred <= 2'd0;
            r_valid    <= '0;
            r_lru      <= '0;
        end else if (r_state == ST_READ) begin
            r_hit      <= w_hit;
            r_hit_way  <= w_hit_way;
            r_hit_pred <= rd_pred[w_hit_way];
            r_valid    <= rd_valid;
            r_lru      <= rd_lru;
        end
    end

    // ------------------------------------------------------------------
    // WRITE: choose the way, compute new predictor and PLRU state
    // ------------------------------------------------------------------
    logic        w_any_invalid;
    logic [1:0]  w_first_invalid;
    logic [1:0]  w_victim;
    logic [1:0]  w_way;
    lc3b_btb_lru w_lru_nxt;
    logic        w_do_write;

    always_comb begin
        w_any_invalid   = 1'b0;
        w_first_invalid = 2'd0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w]) begin
                w_any_invalid   = 1'b1;
                w_first_invalid = 2'(w);
            end
        end
    end

    assign w_way = r_hit         ? r_hit_way       :
                   w_any_invalid ? w_first_invalid : w_victim;

    btb_plru u_plru (
        .lru      (r_lru),
        .way      (w_way),
        .victim   (w_victim),
        .next_lru (w_lru_nxt)
    );

    // A not-taken branch that misses is not worth a BTB entry.
    assign w_do_write = (r_state == ST_WRITE) && (r_hit || w_head.taken);

    always_comb begin
        wr_en     = 1'b0;
        wr_index  = '0;
        wr_way    = 2'd0;
        wr_tag    = '0;
        wr_target = '0;
        wr_pred   = 2'd0;
        wr_lru_en = 1'b0;
        wr_lru    = '0;
        if (w_do_write) begin
            wr_en     = 1'b1;
            wr_index  = w_head.index;
            wr_way    = w_way;
            wr_tag    = w_head.tag;
            wr_target = w_head.target;
            wr_pred   = r_hit ? btb_pred_next(r_hit_pred, w_head.taken)
                              : BTB_PRED_INIT;
            wr_lru_en = 1'b1;
            wr_lru    = w_lru_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_btb_update.sv
// ============================================================================
//  Module      : tb_btb_update
//  Description : Directed self-checking bench for btb_update with a
//                behavioural BTB storage array behind the read/write ports.
//  Revision    : 1.0  initial BTB update slice
// ============================================================================
`default_nettype none

module tb_btb_update;
    import lc3b_type::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    btb_update_if upd ();

    logic [2:0]          rd_index;
    lc3b_btb_tag  [3:0]  rd_tag;
    logic         [3:0]  rd_valid;
    lc3b_btb_pred [3:0]  rd_pred;
    lc3b_btb_lru         rd_lru;
    logic                wr_en;
    logic [2:0]          wr_index;
    logic [1:0]          wr_way;
    lc3b_btb_tag         wr_tag;
    lc3b_word            wr_target;
    lc3b_btb_pred        wr_pred;
    logic                wr_lru_en;
    lc3b_btb_lru         wr_lru;
    logic                busy;

    btb_update #(.WAYS(4), .SETS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .upd       (upd),
        .rd_index  (rd_index),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_pred   (rd_pred),
        .rd_lru    (rd_lru),
        .wr_en     (wr_en),
        .wr_index  (wr_index),
        .wr_way    (wr_way),
        .wr_tag    (wr_tag),
        .wr_target (wr_target),
        .wr_pred   (wr_pred),
        .wr_lru_en (wr_lru_en),
        .wr_lru    (wr_lru),
        .busy      (busy)
    );

    // ------------------------------------------------------------------
    // Storage model (single writer process) and write log
    // ------------------------------------------------------------------
    lc3b_btb_tag  m_tag    [8][4];
    logic         m_valid  [8][4];
    lc3b_btb_pred m_pred   [8][4];
    lc3b_word     m_target [8][4];
    lc3b_btb_lru  m_lru    [8];

    logic         p_clr    = 1'b0;
    logic         p_en     = 1'b0;
    logic [2:0]   p_set    = '0;
    logic [1:0]   p_way    = '0;
    logic         p_valid  = 1'b0;
    lc3b_btb_tag  p_tag    = '0;
    lc3b_btb_pred p_pred   = '0;
    logic         p_lru_en = 1'b0;
    lc3b_btb_lru  p_lru    = '0;

    typedef struct {
        logic [2:0]   index;
        logic [1:0]   way;
        lc3b_btb_tag  tag;
        lc3b_word     target;
        lc3b_btb_pred pred;
        logic         lru_en;
        lc3b_btb_lru  lru;
    } wlog_t;
    wlog_t log_q[$];

    always_comb begin
        for (int w = 0; w < 4; w++) begin
            rd_tag[w]   = m_tag[rd_index][w];
            rd_valid[w] = m_valid[rd_index][w];
            rd_pred[w]  = m_pred[rd_index][w];
        end
        rd_lru = m_lru[rd_index];
    end

    always @(posedge clk) begin
        if (p_clr) begin
            for (int s = 0; s < 8; s++) begin
                m_lru[s] <= '0;
                for (int w = 0; w < 4; w++) begin
                    m_tag[s][w]    <= '0;
                    m_valid[s][w]  <= 1'b0;
                    m_pred[s][w]   <= '0;
                    m_target[s][w] <= '0;
                end
            end
        end else begin
            if (wr_en) begin
                m_tag[wr_index][wr_way]    <= wr_tag;
                m_valid[wr_index][wr_way]  <= 1'b1;
                m_pred[wr_index][wr_way]   <= wr_pred;
                m_target[wr_index][wr_way] <= wr_target;
                log_q.push_back('{wr_index, wr_way, wr_tag, wr_target,
                                  wr_pred, wr_lru_en, wr_lru});
            end
            if (wr_lru_en) m_lru[wr_index] <= wr_lru;
            if (p_en) begin
                m_tag[p_set][p_way]   <= p_tag;
                m_valid[p_set][p_way] <= p_valid;
                m_pred[p_set][p_way]  <= p_pred;
            end
            if (p_lru_en) m_lru[p_set] <= p_lru;
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_log(input string name, input int k,
                             input logic [2:0] idx, input logic [1:0] way,
                             input lc3b_btb_tag tag, input lc3b_word tgt,
                             input lc3b_btb_pred pred, input lc3b_btb_lru lru);
        if (log_q.size() <= k) begin
            check({name, "_present"}, log_q.size(), k + 1);
        end else begin
            check({name, "_index"},  log_q[k].index,  idx);
            check({name, "_way"},    log_q[k].way,    way);
            check({name, "_tag"},    log_q[k].tag,    tag);
            check({name, "_target"}, log_q[k].target, tgt);
            check({name, "_pred"},   log_q[k].pred,   pred);
            check({name, "_lru_en"}, log_q[k].lru_en, 1);
            check({name, "_lru"},    log_q[k].lru,    lru);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers (all start and end on a falling edge)
    // ------------------------------------------------------------------
    task automatic clear_all();
        p_clr = 1'b1;
        @(negedge clk);
        p_clr = 1'b0;
    endtask

    task automatic preset_way(input logic [2:0] s, input logic [1:0] w,
                              input logic v, input lc3b_btb_tag t,
                              input lc3b_btb_pred p);
        p_en = 1'b1; p_set = s; p_way = w; p_valid = v; p_tag = t; p_pred = p;
        @(negedge clk);
        p_en = 1'b0;
    endtask

    task automatic preset_lru(input logic [2:0] s, input lc3b_btb_lru l);
        p_lru_en = 1'b1; p_set = s; p_lru = l;
        @(negedge clk);
        p_lru_en = 1'b0;
    endtask

    task automatic send(input lc3b_word pc, input lc3b_word tgt, input logic tk);
        upd.upd_valid  = 1'b1;
        upd.upd_pc     = pc;
        upd.upd_target = tgt;
        upd.upd_taken  = tk;
        @(negedge clk);
        upd.upd_valid  = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin
        upd.upd_valid  = 1'b0;
        upd.upd_pc     = '0;
        upd.upd_target = '0;
        upd.upd_taken  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_upd_ready", upd.upd_ready, 0);
        check("rst_busy",      busy,          0);
        check("rst_wr_en",     wr_en,         0);
        check("rst_wr_lru_en", wr_lru_en,     0);
        check("rst_rd_index",  rd_index,      0);
        clear_all();
        rst = 1'b0;
        #1;
        check("post_rst_ready", upd.upd_ready, 1);
        @(negedge clk);

        // Empty set allocate + latency: accept edge, IDLE, READ, WRITE
        log_q.delete();
        send(16'h1234, 16'h2000, 1'b1);
        check("lat_busy",      busy,  1);
        check("lat_idle_wren", wr_en, 0);
        @(negedge clk);
        check("lat_rd_index",  rd_index, 2);
        check("lat_read_wren", wr_en,    0);
        @(negedge clk);
        check("lat_wr_en",     wr_en,     1);
        check("lat_wr_index",  wr_index,  2);
        check("lat_wr_way",    wr_way,    0);
        check("lat_wr_tag",    wr_tag,    12'h123);
        check("lat_wr_target", wr_target, 16'h2000);
        check("lat_wr_pred",   wr_pred,   2);
        check("lat_wr_lru_en", wr_lru_en, 1);
        check("lat_wr_lru",    wr_lru,    3'b011);
        check("lat_rd_idx_wr", rd_index,  0);
        @(negedge clk);
        check("lat_wr_en_off", wr_en,   0);
        check("lat_busy_off",  busy,    0);
        check("lat_nwrites",   log_q.size(), 1);

        // Hit way 2, saturate up then down
        preset_way(3'd3, 2'd0, 1'b1, 12'h011, 2'd1);
        preset_way(3'd3, 2'd1, 1'b1, 12'h022, 2'd1);
        preset_way(3'd3, 2'd2, 1'b1, 12'h0A5, 2'd3);
        preset_lru(3'd3, 3'b010);
        log_q.delete();
        send(16'h0A56, 16'h3000, 1'b1);
        wait_idle(10);
        check_log("hit_sat_up", 0, 3'd3, 2'd2, 12'h0A5, 16'h3000, 2'd3, 3'b110);
        preset_way(3'd3, 2'd2, 1'b1, 12'h0A5, 2'd0);
        log_q.delete();
        send(16'h0A56, 16'h3002, 1'b0);
        wait_idle(10);
        check_log("hit_sat_dn", 0, 3'd3, 2'd2, 12'h0A5, 16'h3002, 2'd0, 3'b110);

        // Two matching ways: lowest wins
        preset_way(3'd5, 2'd1, 1'b1, 12'h777, 2'd1);
        preset_way(3'd5, 2'd3, 1'b1, 12'h777, 2'd3);
        log_q.delete();
        send(16'h777A, 16'h4000, 1'b1);
        wait_idle(10);
        check_log("multi_hit", 0, 3'd5, 2'd1, 12'h777, 16'h4000, 2'd2, 3'b001);

        // Miss with an invalid way: lowest invalid, not the PLRU victim
        preset_way(3'd6, 2'd0, 1'b1, 12'hAAA, 2'd1);
        preset_way(3'd6, 2'd2, 1'b1, 12'hBBB, 2'd1);
        log_q.delete();
        send(16'h888C, 16'h7000, 1'b1);
        wait_idle(10);
        check_log("alloc_inv", 0, 3'd6, 2'd1, 12'h888, 16'h7000, 2'd2, 3'b001);

        // Full set, PLRU victim, then not-taken miss
        for (int w = 0; w < 4; w++) preset_way(3'd4, 2'(w), 1'b1, 12'(w + 1), 2'd0);
        preset_lru(3'd4, 3'b101);
        log_q.delete();
        send(16'h4448, 16'h5000, 1'b1);
        wait_idle(10);
        check_log("victim", 0, 3'd4, 2'd3, 12'h444, 16'h5000, 2'd2, 3'b000);
        log_q.delete();
        send(16'h5558, 16'h6000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("nt_miss_wr_en",  wr_en,     0);
        check("nt_miss_lru_en", wr_lru_en, 0);
        check("nt_miss_busy",   busy,      1);
        @(negedge clk);
        check("nt_miss_busy_off", busy, 0);
        check("nt_miss_nwrites",  log_q.size(), 0);

        // Three back-to-back requests to one set
        log_q.delete();
        upd.upd_valid  = 1'b1;
        upd.upd_pc     = 16'h999E;
        upd.upd_taken  = 1'b1;
        upd.upd_target = 16'h1111;
        check("b2b_ready_a", upd.upd_ready, 1);
        @(negedge clk);
        upd.upd_target = 16'h2222;
        check("b2b_ready_b", upd.upd_ready, 1);
        @(negedge clk);
        upd.upd_target = 16'h3333;
        check("b2b_full", upd.upd_ready, 0);
        @(negedge clk);
        check("b2b_full_on_pop", upd.upd_ready, 0);
        check("b2b_first_wr",    wr_en,         1);
        @(negedge clk);
        check("b2b_ready_c", upd.upd_ready, 1);
        @(negedge clk);
        upd.upd_valid = 1'b0;
        wait_idle(20);
        check("b2b_nwrites", log_q.size(), 3);
        check_log("b2b_a", 0, 3'd7, 2'd0, 12'h999, 16'h1111, 2'd2, 3'b011);
        check_log("b2b_b", 1, 3'd7, 2'd0, 12'h999, 16'h2222, 2'd3, 3'b011);
        check_log("b2b_c", 2, 3'd7, 2'd0, 12'h999, 16'h3333, 2'd3, 3'b011);

        // Reset during WRITE with two entries queued
        log_q.delete();
        send(16'hABC2, 16'h8000, 1'b1);
        send(16'hABC2, 16'h8002, 1'b1);
        @(negedge clk);
        check("mid_rst_pre_wr_en", wr_en, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_wr_en",    wr_en,         0);
        check("mid_rst_lru_en",   wr_lru_en,     0);
        check("mid_rst_busy",     busy,          0);
        check("mid_rst_ready",    upd.upd_ready, 0);
        check("mid_rst_rd_index", rd_index,      0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_ready_after", upd.upd_ready, 1);
        repeat (8) @(negedge clk);
        check("mid_rst_nwrites",  log_q.size(),    0);
        check("mid_rst_busy_end", busy,            0);
        check("mid_rst_set_empty", m_valid[1][0],  0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/btb_update.md
BTB_UPDATE -- requirements
Module: btb_update

Interface
REQ-001 SHALL have parameter WAYS, default 4, associativity; only 4 is supported.
REQ-002 SHALL have parameter SETS, default 8, number of sets; index = pc[3:1], tag = pc[15:4], pc[0] ignored.
REQ-003 SHALL have clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have upd_valid  input  1, upd_pc  input  16 (lc3b_word), upd_target  input  16, upd_taken  input  1: resolved-branch update request from execute.
REQ-006 SHALL have upd_ready  output  1  update can be accepted this cycle.
REQ-007 SHALL have rd_index  output  3  set index presented to BTB storage read port.
REQ-008 SHALL have rd_tag  input  4x12, rd_valid  input  4x1, rd_pred  input  4x2, rd_lru  input  3: set contents returned combinationally for rd_index.
REQ-009 SHALL have wr_en  output  1, wr_index  output  3, wr_way  output  2, wr_tag  output  12, wr_target  output  16, wr_pred  output  2: single-entry write port; storage sets valid on write.
REQ-010 SHALL have wr_lru_en  output  1, wr_lru  output  3: LRU write for wr_index.
REQ-011 SHALL have busy  output  1  FIFO non-empty or FSM not IDLE.

Function
REQ-012 SHALL buffer requests in a 2-entry FIFO; upd_ready = FIFO not full; request accepted when upd_valid & upd_ready.
REQ-013 SHALL not accept when full, even if a pop occurs the same cycle; push and pop in the same cycle when not full SHALL both take effect.
REQ-014 SHALL implement FSM IDLE, READ, WRITE: IDLE->READ when FIFO non-empty; READ->WRITE always; WRITE->READ if FIFO still non-empty after pop, else IDLE.
REQ-015 In READ SHALL drive rd_index from FIFO head and register hit, hit way, rd_pred, rd_valid, rd_lru; rd_index outside READ is don't-care and SHALL be held at 0.
REQ-016 Hit = rd_valid[w] & (rd_tag[w] == head tag); multiple hits SHALL select lowest w.
REQ-017 In WRITE SHALL pop the FIFO head exactly once.
REQ-018 Hit: SHALL write the hit way, head target, pred saturating (taken: min(p+1,3); not-taken: max(p-1,0)).
REQ-019 Miss and taken: SHALL allocate the lowest invalid way, else the PLRU victim; pred = 2'b10.
REQ-020 Miss and not-taken: SHALL leave wr_en and wr_lru_en at 0 and still pop.
REQ-021 PLRU victim: b0=0 -> b1 ? way1 : way0; b0=1 -> b2 ? way3 : way2.
REQ-022 PLRU touch of way w: w<2 -> b0=1, b1=(w==0), b2 unchanged; w>=2 -> b0=0, b2=(w==2), b1 unchanged.
REQ-023 wr_en and wr_lru_en SHALL be asserted together for exactly one cycle in WRITE; all wr_* outputs SHALL be 0 otherwise.
REQ-024 Latency: accepted into empty FIFO with FSM IDLE -> wr_en 2 cycles later; throughput one update per 2 cycles.
REQ-025 Back-to-back updates to the same set SHALL observe the preceding write, since READ follows the WRITE edge.

Reset
REQ-026 rst SHALL force FSM IDLE, FIFO empty, busy 0, upd_ready 0 while asserted, and all wr_* outputs and rd_index 0.
REQ-027 rst mid-operation SHALL discard pending entries and suppress any in-flight write; upd_ready SHALL rise the first cycle after deassertion.

Structure
REQ-028 lc3b_type SHALL gain lc3b_btb_index (3b), lc3b_btb_tag (12b), lc3b_btb_pred (2b), lc3b_btb_lru (3b) and constant BTB_PRED_INIT = 2'b10.
REQ-029 SHALL instantiate one combinational sub-module btb_plru (inputs lru, touched way; outputs victim, next lru) shared with the BTB lookup path.

Verification
REQ-030 Empty set, pc=0x1234 taken target 0x2000 -> wr_en at cycle +2, index 2, way 0, tag 0x123, pred 2, lru 3'b011.
REQ-031 Hit way 2 with pred 3, taken -> pred stays 3; pred 0, not-taken -> stays 0; wr_lru = {b2=1, b1 unchanged, b0=0}.
REQ-032 Full set, lru 3'b101, miss taken -> wr_way 3; miss not-taken -> no wr_en, busy drops after pop.
REQ-033 Three consecutive upd_valid cycles -> third stalls (upd_ready 0) until first pop; all three written in order to the same set with correct pred chain 2->3->3.
REQ-034 rst asserted during WRITE with 2 entries queued -> wr_en 0 immediately, busy 0, no writes after deassertion.
